// File: rtl/fcc_pkg.sv
// Shared types and defaults for the FCC block-RAM stream controller.
package fcc_pkg;
   localparam int FCC_DWIDTH   = 16;
   localparam int FCC_AWIDTH   = 12;
   localparam int FCC_MEM_SIZE = 3840;
   // Output buffer depth: one slot covers the RAM read latency, the other
   // covers a cycle of downstream stall.
   localparam int OBUF_DEPTH   = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      DONE  = 2'd3
   } fcc_state_e;
endpackage

// File: rtl/fcc_bram_stream_ctrl_if.sv
// Stream and RAM-port bundle between the controller (master) and its
// surroundings: the input stream source, the output stream sink and the RAM.
interface fcc_bram_stream_ctrl_if #(
   parameter int DWIDTH = fcc_pkg::FCC_DWIDTH,
   parameter int AWIDTH = fcc_pkg::FCC_AWIDTH
);
   logic              s_valid;
   logic              s_ready;
   logic [DWIDTH-1:0] s_data;
   logic              m_valid;
   logic              m_ready;
   logic [DWIDTH-1:0] m_data;
   logic [AWIDTH-1:0] addr0;
   logic              ce0;
   logic              we0;
   logic [DWIDTH-1:0] d0;
   logic [AWIDTH-1:0] addr1;
   logic              ce1;
   logic              we1;
   logic [DWIDTH-1:0] q1;

   modport master (
      input  s_valid, s_data, m_ready, q1,
      output s_ready, m_valid, m_data, addr0, ce0, we0, d0, addr1, ce1, we1
   );

   modport slave (
      output s_valid, s_data, m_ready, q1,
      input  s_ready, m_valid, m_data, addr0, ce0, we0, d0, addr1, ce1, we1
   );
endinterface

// File: rtl/fcc_skid_fifo2.sv
// Two-entry registered FIFO absorbing the RAM read latency in front of the
// output stream. The head entry is presented straight from a register.
module fcc_skid_fifo2 import fcc_pkg::*; #(
   parameter int DWIDTH = FCC_DWIDTH,
   localparam int CW    = $clog2(OBUF_DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              push,
   input  logic [DWIDTH-1:0] din,
   input  logic              pop,
   output logic [DWIDTH-1:0] dout,
   output logic [CW-1:0]     count
);
   // Depth is two, so single-bit pointers wrap by inversion.
   logic [OBUF_DEPTH-1:0][DWIDTH-1:0] mem;
   logic                              wr_ptr;
   logic                              rd_ptr;

   // Storage, pointers and occupancy; the caller never pushes into a full
   // buffer nor pops an empty one.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem    <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

   assign dout = mem[rd_ptr];
endmodule

// File: rtl/fcc_bram_stream_ctrl.sv
// Loads one frame from the input stream into the dual-port RAM via port 0,
// then replays it in address order via port 1 onto the output stream.
module fcc_bram_stream_ctrl import fcc_pkg::*; #(
   parameter int DWIDTH = FCC_DWIDTH,
   parameter int AWIDTH = FCC_AWIDTH
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  i_run,
   input  logic [AWIDTH-1:0]     i_num_cnt,
   output logic                  o_idle,
   output logic                  o_done,
   fcc_bram_stream_ctrl_if.master bus
);
   localparam logic [AWIDTH-1:0] ONE = AWIDTH'(1);

   fcc_state_e        state;
   logic [AWIDTH-1:0] num_r;
   logic [AWIDTH-1:0] wr_cnt;
   logic [AWIDTH-1:0] rd_cnt;
   logic [AWIDTH-1:0] out_cnt;
   logic              s_ready_r;
   logic              in_flight;
   logic              wr_hs;
   logic              rd_issue;
   logic              pop;
   logic              m_valid_w;
   logic [1:0]        occ;
   logic [2:0]        pending;
   logic [DWIDTH-1:0] head;

   assign wr_hs     = s_ready_r & bus.s_valid;
   assign m_valid_w = (occ != 2'd0);
   assign pop       = m_valid_w & bus.m_ready;
   // Slots already claimed after this cycle's pop: buffered plus in flight.
   assign pending   = 3'(occ) + 3'(in_flight) - 3'(pop);
   assign rd_issue  = (state == READ) && (rd_cnt < num_r) && (pending < 3'(OBUF_DEPTH));

   // RAM ports are pure decode of state and counters; port 1 never writes.
   assign bus.s_ready = s_ready_r;
   assign bus.ce0     = wr_hs;
   assign bus.we0     = wr_hs;
   assign bus.addr0   = wr_cnt;
   assign bus.d0      = wr_hs ? bus.s_data : '0;
   assign bus.ce1     = rd_issue;
   assign bus.we1     = 1'b0;
   assign bus.addr1   = rd_cnt;
   assign bus.m_valid = m_valid_w;
   assign bus.m_data  = head;

   // Frame sequencing, counters and registered status outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         o_idle    <= 1'b1;
         o_done    <= 1'b0;
         s_ready_r <= 1'b0;
         in_flight <= 1'b0;
         num_r     <= '0;
         wr_cnt    <= '0;
         rd_cnt    <= '0;
         out_cnt   <= '0;
      end else begin
         o_done    <= 1'b0;
         in_flight <= rd_issue;
         case (state)
            IDLE: if (i_run) begin
               num_r  <= i_num_cnt;
               o_idle <= 1'b0;
               if (i_num_cnt == '0) begin
                  state  <= DONE;
                  o_done <= 1'b1;
               end else begin
                  state     <= WRITE;
                  s_ready_r <= 1'b1;
               end
            end
            WRITE: if (wr_hs) begin
               if (wr_cnt == num_r - ONE) begin
                  state     <= READ;
                  s_ready_r <= 1'b0;
                  wr_cnt    <= '0;
               end else begin
                  wr_cnt <= wr_cnt + ONE;
               end
            end
            READ: begin
               if (rd_issue) rd_cnt <= rd_cnt + ONE;
               if (pop) begin
                  if (out_cnt == num_r - ONE) begin
                     state   <= DONE;
                     o_done  <= 1'b1;
                     out_cnt <= '0;
                     rd_cnt  <= '0;
                  end else begin
                     out_cnt <= out_cnt + ONE;
                  end
               end
            end
            DONE: begin
               state   <= IDLE;
               o_idle  <= 1'b1;
               wr_cnt  <= '0;
               rd_cnt  <= '0;
               out_cnt <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   fcc_skid_fifo2 #(.DWIDTH(DWIDTH)) u_obuf (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (in_flight),
      .din     (bus.q1),
      .pop     (pop),
      .dout    (head),
      .count   (occ)
   );
endmodule

// File: tb/tb_fcc_bram_stream_ctrl.sv
// Bench for fcc_bram_stream_ctrl: a behavioural RAM, a negedge monitor that
// logs every RAM access and output beat, and per-scenario tasks comparing
// those logs with the expected frame (output == input, addresses 0..n-1).
module tb_fcc_bram_stream_ctrl;
   localparam int DW = 16;
   localparam int AW = 12;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          i_run = 1'b0;
   logic [AW-1:0] i_num_cnt = '0;
   logic          o_idle;
   logic          o_done;
   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;

   fcc_bram_stream_ctrl_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

   fcc_bram_stream_ctrl #(.DWIDTH(DW), .AWIDTH(AW)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_run     (i_run),
      .i_num_cnt (i_num_cnt),
      .o_idle    (o_idle),
      .o_done    (o_done),
      .bus       (bus)
   );

   logic [DW-1:0] ram [1<<AW];
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] out_q[$];
   logic [DW-1:0] wr_dat_q[$];
   logic [AW-1:0] wr_addr_q[$];
   logic [AW-1:0] rd_addr_q[$];
   int            wr_cyc_q[$];
   int            rd_cyc_q[$];
   int            out_cyc_q[$];
   int            done_q[$];
   int            bp_q[$];

   always #5 clk = ~clk;

   // cycle counter
   always @(posedge clk) cyc <= cyc + 1;

   // behavioural true dual-port RAM, registered read on port 1
   always @(posedge clk) begin
      if (bus.ce0 && bus.we0) ram[bus.addr0] <= bus.d0;
      if (bus.ce1) bus.q1 <= ram[bus.addr1];
   end

   // monitor: log RAM accesses, output beats, done pulses, over-issue events
   always @(negedge clk) begin
      if (bus.ce1 && (rd_addr_q.size() - out_q.size() - ((bus.m_valid && bus.m_ready) ? 1 : 0)) >= 2)
         bp_q.push_back(cyc);
      if (bus.ce0 && bus.we0) begin
         wr_addr_q.push_back(bus.addr0);
         wr_dat_q.push_back(bus.d0);
         wr_cyc_q.push_back(cyc);
      end
      if (bus.ce1) begin
         rd_addr_q.push_back(bus.addr1);
         rd_cyc_q.push_back(cyc);
      end
      if (bus.m_valid && bus.m_ready) begin
         out_q.push_back(bus.m_data);
         out_cyc_q.push_back(cyc);
      end
      if (o_done) done_q.push_back(cyc);
   end

   task automatic clear_logs();
      out_q.delete(); wr_dat_q.delete(); wr_addr_q.delete(); rd_addr_q.delete();
      wr_cyc_q.delete(); rd_cyc_q.delete(); out_cyc_q.delete(); done_q.delete(); bp_q.delete();
   endtask

   task automatic fill_exp(input int n);
      exp_q.delete();
      for (int i = 0; i < n; i++) exp_q.push_back(DW'($urandom));
   endtask

   // model: the output stream must equal the input frame word for word
   function automatic int out_bad();
      int b = (out_q.size() == exp_q.size()) ? 0 : 1;
      for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
         if (out_q[i] !== exp_q[i]) b++;
      return b;
   endfunction

   // model: word i of the frame is written to address i
   function automatic int wr_bad();
      int b = (wr_addr_q.size() == exp_q.size()) ? 0 : 1;
      for (int i = 0; i < wr_addr_q.size() && i < exp_q.size(); i++)
         if (wr_addr_q[i] !== AW'(i) || wr_dat_q[i] !== exp_q[i]) b++;
      return b;
   endfunction

   // model: each address 0..n-1 is read exactly once, in order
   function automatic int rd_bad();
      int b = (rd_addr_q.size() == exp_q.size()) ? 0 : 1;
      for (int i = 0; i < rd_addr_q.size() && i < exp_q.size(); i++)
         if (rd_addr_q[i] !== AW'(i)) b++;
      return b;
   endfunction

   function automatic int post_done();
      int b = 0;
      if (done_q.size() == 0) return 0;
      foreach (out_cyc_q[i]) if (out_cyc_q[i] >= done_q[0]) b++;
      return b;
   endfunction

   // Drive one frame of exp_q. rdy_mode: 0 always ready, 1 pattern 1,0,0,1,
   // 2 random. glitch pulses i_run with another length during WRITE.
   // abort_at>0 stops once that many beats have been offered and accepted.
   task automatic run_frame(input int n, input int gap_pct, input int rdy_mode,
                            input int glitch, input int abort_at);
      int wi = 0;
      int k;
      int bound = 6 * n + 50;
      clear_logs();
      @(posedge clk); #1;
      i_run = 1'b1; i_num_cnt = AW'(n);
      @(posedge clk); #1;
      i_run = 1'b0; i_num_cnt = AW'($urandom);
      for (k = 0; k < bound; k++) begin
         if (wi < n && int'($urandom_range(99)) >= gap_pct) begin
            bus.s_valid = 1'b1; bus.s_data = exp_q[wi];
         end else begin
            bus.s_valid = 1'b0; bus.s_data = DW'($urandom);
         end
         case (rdy_mode)
            0:       bus.m_ready = 1'b1;
            1:       bus.m_ready = (k % 4 == 0) || (k % 4 == 3);
            default: bus.m_ready = 1'($urandom_range(1));
         endcase
         i_run = (glitch != 0 && k == 2);
         if (glitch != 0 && k == 2) i_num_cnt = AW'(n + 3);
         @(negedge clk); #1;
         if (bus.s_valid && bus.s_ready) wi++;
         if (done_q.size() != 0) break;
         if (abort_at > 0 && out_q.size() >= abort_at) break;
         @(posedge clk); #1;
      end
      checks++;
      if (k >= bound) begin
         errors++;
         $display("FAIL frame_timeout n=%0d: no o_done after %0d cycles, required o_done", n, k);
      end
      if (abort_at > 0) return;
      @(posedge clk); #1;
      bus.s_valid = 1'b0; i_run = 1'b0; bus.m_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; bus.s_valid = 1'b1; bus.s_data = '1; bus.m_ready = 1'b1;
      i_run = 1'b1; i_num_cnt = AW'(5);
      repeat (2) @(negedge clk);
      checks++;
      if (o_idle !== 1'b1 || o_done !== 1'b0) begin
         errors++; $display("FAIL reset_status: o_idle=%b o_done=%b, required 1 0", o_idle, o_done);
      end
      checks++;
      if (bus.s_ready !== 1'b0 || bus.m_valid !== 1'b0 || bus.m_data !== '0) begin
         errors++; $display("FAIL reset_stream: s_ready=%b m_valid=%b m_data=%h, required 0 0 0000",
                            bus.s_ready, bus.m_valid, bus.m_data);
      end
      checks++;
      if ({bus.ce0, bus.we0, bus.ce1, bus.we1} !== 4'b0 || bus.addr0 !== '0 || bus.addr1 !== '0 || bus.d0 !== '0) begin
         errors++; $display("FAIL reset_ram: ce0/we0/ce1/we1=%b%b%b%b addr0=%h addr1=%h d0=%h, required all 0",
                            bus.ce0, bus.we0, bus.ce1, bus.we1, bus.addr0, bus.addr1, bus.d0);
      end
      i_run = 1'b0; bus.s_valid = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
   endtask

   task automatic test_basic();
      int lw;
      exp_q = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
      run_frame(4, 0, 0, 0, 0);
      checks++;
      if (wr_bad() !== 0) begin
         errors++; $display("FAIL basic_writes: %0d bad writes, required 0", wr_bad());
      end
      checks++;
      if (out_bad() !== 0) begin
         errors++; $display("FAIL basic_data: %0d bad beats of %0d, required 0", out_bad(), out_q.size());
      end
      lw = (wr_cyc_q.size() == 4) ? wr_cyc_q[3] : -100;
      checks++;
      if (rd_cyc_q.size() == 0 || rd_cyc_q[0] !== lw + 1) begin
         errors++; $display("FAIL basic_first_read: first ce1 cycle %0d, required %0d",
                            (rd_cyc_q.size() != 0) ? rd_cyc_q[0] : -1, lw + 1);
      end
      checks++;
      if (out_cyc_q.size() != 4 || out_cyc_q[0] !== lw + 3 || out_cyc_q[3] !== lw + 6) begin
         errors++; $display("FAIL basic_latency: beats at %0d..%0d, required %0d..%0d",
                            (out_cyc_q.size() != 0) ? out_cyc_q[0] : -1,
                            (out_cyc_q.size() != 0) ? out_cyc_q[$] : -1, lw + 3, lw + 6);
      end
      checks++;
      if (done_q.size() !== 1 || o_idle !== 1'b1) begin
         errors++; $display("FAIL basic_done: %0d done pulses o_idle=%b, required 1 1", done_q.size(), o_idle);
      end
   endtask

   task automatic test_backpressure();
      fill_exp(8);
      run_frame(8, 0, 1, 0, 0);
      checks++;
      if (out_bad() !== 0) begin
         errors++; $display("FAIL bp_data: %0d bad beats of %0d, required 0", out_bad(), out_q.size());
      end
      checks++;
      if (rd_bad() !== 0) begin
         errors++; $display("FAIL bp_read_addr: %0d bad reads, required 0", rd_bad());
      end
      checks++;
      if (bp_q.size() !== 0) begin
         errors++; $display("FAIL bp_overissue: %0d reads issued with 2 outstanding, required 0", bp_q.size());
      end
      checks++;
      if (done_q.size() !== 1) begin
         errors++; $display("FAIL bp_done: %0d done pulses, required 1", done_q.size());
      end
   endtask

   task automatic test_zero_len();
      clear_logs();
      @(posedge clk); #1;
      i_run = 1'b1; i_num_cnt = '0;
      @(posedge clk); #1;
      i_run = 1'b0;
      checks++;
      if (o_done !== 1'b1 || o_idle !== 1'b0) begin
         errors++; $display("FAIL zero_done: o_done=%b o_idle=%b, required 1 0", o_done, o_idle);
      end
      @(posedge clk); #1;
      checks++;
      if (o_done !== 1'b0 || o_idle !== 1'b1) begin
         errors++; $display("FAIL zero_idle: o_done=%b o_idle=%b, required 0 1", o_done, o_idle);
      end
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (wr_addr_q.size() + rd_addr_q.size() !== 0 || done_q.size() !== 1) begin
         errors++; $display("FAIL zero_activity: %0d RAM accesses %0d done pulses, required 0 1",
                            wr_addr_q.size() + rd_addr_q.size(), done_q.size());
      end
   endtask

   task automatic test_run_during_write();
      fill_exp(8);
      run_frame(8, 0, 0, 1, 0);
      checks++;
      if (out_q.size() !== 8 || out_bad() !== 0) begin
         errors++; $display("FAIL glitch_len: %0d beats %0d bad, required 8 0", out_q.size(), out_bad());
      end
      checks++;
      if (wr_bad() !== 0 || done_q.size() !== 1) begin
         errors++; $display("FAIL glitch_frame: %0d bad writes %0d done pulses, required 0 1",
                            wr_bad(), done_q.size());
      end
   endtask

   task automatic test_back_to_back();
      for (int f = 0; f < 4; f++) begin
         int n = (f == 0) ? 1 : int'($urandom_range(20, 2));
         fill_exp(n);
         run_frame(n, 30, 2, 0, 0);
         checks++;
         if (out_bad() !== 0 || rd_bad() !== 0) begin
            errors++; $display("FAIL b2b_frame%0d n=%0d: %0d bad beats %0d bad reads, required 0 0",
                               f, n, out_bad(), rd_bad());
         end
         checks++;
         if (done_q.size() !== 1 || post_done() !== 0) begin
            errors++; $display("FAIL b2b_done%0d: %0d done pulses %0d late beats, required 1 0",
                               f, done_q.size(), post_done());
         end
      end
   endtask

   task automatic test_reset_mid();
      fill_exp(10);
      run_frame(10, 0, 0, 0, 5);
      @(posedge clk); #1;
      bus.m_ready = 1'b0;
      reset_n = 1'b0;
      #1;
      checks++;
      if (bus.m_valid !== 1'b0 || o_idle !== 1'b1 || bus.ce1 !== 1'b0) begin
         errors++; $display("FAIL midreset_state: m_valid=%b o_idle=%b ce1=%b, required 0 1 0",
                            bus.m_valid, o_idle, bus.ce1);
      end
      checks++;
      if (done_q.size() !== 0 || out_q.size() !== 5) begin
         errors++; $display("FAIL midreset_progress: %0d done pulses %0d beats, required 0 5",
                            done_q.size(), out_q.size());
      end
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      fill_exp(2);
      run_frame(2, 0, 0, 0, 0);
      checks++;
      if (out_bad() !== 0 || done_q.size() !== 1) begin
         errors++; $display("FAIL midreset_next: %0d bad beats of %0d, %0d done pulses, required 0 1",
                            out_bad(), out_q.size(), done_q.size());
      end
   endtask

   task automatic test_max_frame();
      fill_exp(3839);
      run_frame(3839, 25, 2, 0, 0);
      checks++;
      if (out_bad() !== 0 || wr_bad() !== 0) begin
         errors++; $display("FAIL max_data: %0d bad beats %0d bad writes, required 0 0", out_bad(), wr_bad());
      end
      checks++;
      if (rd_bad() !== 0 || rd_addr_q.size() == 0 || rd_addr_q[$] !== AW'(3838)) begin
         errors++; $display("FAIL max_read_addr: %0d bad reads last addr1=%0d, required 0 3838",
                            rd_bad(), (rd_addr_q.size() != 0) ? int'(rd_addr_q[$]) : -1);
      end
      checks++;
      if (bp_q.size() !== 0 || post_done() !== 0 || done_q.size() !== 1) begin
         errors++; $display("FAIL max_flow: %0d over-issues %0d late beats %0d done pulses, required 0 0 1",
                            bp_q.size(), post_done(), done_q.size());
      end
   endtask

   initial begin
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.m_ready = 1'b0;
      test_reset();
      test_basic();
      test_backpressure();
      test_zero_len();
      test_run_during_write();
      test_back_to_back();
      test_reset_mid();
      test_max_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
